// File: rtl/maxpool_reader.sv
// 2x2 max-pooling reader: walks an SxS frame, pairs each odd row with the
// previous row from the row stacks, and emits one result per window. MAXPOOL_RELU_EN clamps negatives to zero.
module maxpool_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] SIZE_maxpooling_IN,
    input  logic [7:0] pix_in1,
    input  logic [7:0] pix_in2,
    input  logic [7:0] stk_out1,
    input  logic [7:0] stk_out2,
    output logic [8:0] col,
    output logic [7:0] pool_out1,
    output logic [7:0] pool_out2,
    output logic       pool_valid,
    output logic       frame_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_POOL = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_size;
    logic [8:0] r_col;
    logic [8:0] r_row;
    logic [7:0] r_h1;
    logic [7:0] r_h2;
    logic [7:0] r_pool_out1;
    logic [7:0] r_pool_out2;
    logic       r_pool_valid;
    logic       r_frame_done;

    logic [7:0] w_size;
    logic [8:0] w_size9;
    logic       w_last_col;
    logic       w_last;
    logic [7:0] w_vmax1;
    logic [7:0] w_vmax2;

    function automatic logic [7:0] f_smax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [7:0] f_post(input logic [7:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    // In IDLE the incoming size applies to the very pixel that starts the frame.
    always_comb begin
        w_size     = (r_state == ST_IDLE) ? SIZE_maxpooling_IN : r_size;
        w_size9    = {1'b0, w_size};
        w_last_col = (w_size9 == r_col + 9'd1);
        w_last     = (w_size == 8'd0) || (w_last_col && (w_size9 == r_row + 9'd1));
        w_vmax1    = f_smax(pix_in1, stk_out1);
        w_vmax2    = f_smax(pix_in2, stk_out2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_size       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_h1         <= '0;
            r_h2         <= '0;
            r_pool_out1  <= '0;
            r_pool_out2  <= '0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (en) begin
                if (r_state == ST_IDLE) begin
                    r_size <= SIZE_maxpooling_IN;
                end
                // Odd S: the trailing even column only loads h and never completes.
                if (r_state == ST_POOL) begin
                    if (!r_col[0]) begin
                        r_h1 <= w_vmax1;
                        r_h2 <= w_vmax2;
                    end else begin
                        r_pool_out1  <= f_post(f_smax(r_h1, w_vmax1));
                        r_pool_out2  <= f_post(f_smax(r_h2, w_vmax2));
                        r_pool_valid <= 1'b1;
                    end
                end
                if (w_last) begin
                    r_state      <= ST_IDLE;
                    r_col        <= '0;
                    r_row        <= '0;
                    r_frame_done <= 1'b1;
                end else if (w_last_col) begin
                    r_col   <= '0;
                    r_row   <= r_row + 9'd1;
                    r_state <= r_row[0] ? ST_FILL : ST_POOL;
                end else begin
                    r_col <= r_col + 9'd1;
                    if (r_state == ST_IDLE) begin
                        r_state <= ST_FILL;
                    end
                end
            end
        end
    end

    assign col        = r_col;
    assign pool_out1  = r_pool_out1;
    assign pool_out2  = r_pool_out2;
    assign pool_valid = r_pool_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_reader.sv
// Randomized self-checking bench for maxpool_reader; expected windows are
// computed per frame from the stored pixel arrays.
module tb_maxpool_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] size_in;
    logic [7:0] pix1, pix2, stk1, stk2;
    logic [8:0] col;
    logic [7:0] pool_out1, pool_out2;
    logic       pool_valid, frame_done;

    always #5 clk = ~clk;

    maxpool_reader dut (
        .clk(clk), .rst_n(rst_n), .en(en), .SIZE_maxpooling_IN(size_in),
        .pix_in1(pix1), .pix_in2(pix2), .stk_out1(stk1), .stk_out2(stk2),
        .col(col), .pool_out1(pool_out1), .pool_out2(pool_out2),
        .pool_valid(pool_valid), .frame_done(frame_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] p1 [16][16];
    logic [7:0] p2 [16][16];
    logic [7:0] s1 [16][16];
    logic [7:0] s2 [16][16];
    logic [7:0] exp_out1 = 8'h00;
    logic [7:0] exp_out2 = 8'h00;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int smax(input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = int'($signed(a));
        y = int'($signed(b));
        return (x > y) ? x : y;
    endfunction

    function automatic logic [7:0] win_max(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        int m;
        m = smax(a, b);
        if (int'($signed(c)) > m) m = int'($signed(c));
        if (int'($signed(d)) > m) m = int'($signed(d));
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return 8'(m);
    endfunction

    task automatic fill_rand(input int s);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                p1[r][c] = 8'($urandom); p2[r][c] = 8'($urandom);
                s1[r][c] = 8'($urandom); s2[r][c] = 8'($urandom);
            end
    endtask

    task automatic fill_const(input logic [7:0] pv, input logic [7:0] sv);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                p1[r][c] = pv; s1[r][c] = sv;
                p2[r][c] = sv; s2[r][c] = pv;
            end
    endtask

    // Idle cycle: random garbage on the data inputs must change nothing.
    task automatic idle_cycle(input int exp_col);
        en = 1'b0;
        pix1 = 8'($urandom); pix2 = 8'($urandom);
        stk1 = 8'($urandom); stk2 = 8'($urandom);
        #1 check("col_idle", 16'(col), 16'(exp_col));
        @(posedge clk); #1;
        check("valid_idle", 16'(pool_valid), 16'd0);
        check("done_idle", 16'(frame_done), 16'd0);
        check("hold1", 16'(pool_out1), 16'(exp_out1));
        check("hold2", 16'(pool_out2), 16'(exp_out2));
    endtask

    // gap: 0 continuous en, 1 en alternating 1/0, 2 random gaps
    task automatic run_frame(input int s, input int lim, input int gap);
        int npix, half, r, c, nidle;
        logic exp_v;
        npix = (s == 0) ? 1 : s * s;
        half = s / 2;
        if (lim > npix) lim = npix;
        size_in = 8'(s);
        for (int k = 0; k < lim; k++) begin
            r = (s == 0) ? 0 : k / s;
            c = (s == 0) ? 0 : k % s;
            nidle = (gap == 1) ? ((k == 0) ? 0 : 1) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i < nidle; i++) idle_cycle(c);
            en = 1'b1;
            pix1 = p1[r][c]; pix2 = p2[r][c];
            stk1 = s1[r][c]; stk2 = s2[r][c];
            #1 check("col", 16'(col), 16'(c));
            @(posedge clk); #1;
            size_in = 8'($urandom);
            exp_v = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * half) && (c < 2 * half);
            if (exp_v) begin
                exp_out1 = win_max(p1[r][c-1], s1[r][c-1], p1[r][c], s1[r][c]);
                exp_out2 = win_max(p2[r][c-1], s2[r][c-1], p2[r][c], s2[r][c]);
            end
            check("valid", 16'(pool_valid), 16'(exp_v));
            check("done", 16'(frame_done), 16'(k == npix - 1));
            check("out1", 16'(pool_out1), 16'(exp_out1));
            check("out2", 16'(pool_out2), 16'(exp_out2));
        end
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; size_in = '0;
        pix1 = '0; pix2 = '0; stk1 = '0; stk2 = '0;
        #12;
        check("rst_col", 16'(col), 16'd0);
        check("rst_out", {pool_out1, pool_out2}, 16'h0000);
        check("rst_flags", {14'd0, pool_valid, frame_done}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        fill_const(8'h10, 8'h10);
        run_frame(4, 1000, 0);
        idle_cycle(0);

        fill_rand(2);
        p1[1][0] = 8'h05; p1[1][1] = 8'h7F; s1[1][0] = 8'h80; s1[1][1] = 8'h03;
        run_frame(2, 1000, 0);
        idle_cycle(0);

        fill_const(8'hF0, 8'hF8);
        run_frame(2, 1000, 2);
        idle_cycle(0);

        fill_rand(5);
        run_frame(5, 1000, 1);
        idle_cycle(0);

        fill_rand(1);
        run_frame(1, 1000, 2);
        run_frame(0, 1000, 0);
        run_frame(0, 1000, 2);
        idle_cycle(0);

        fill_rand(4);
        run_frame(4, 9, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_col", 16'(col), 16'd0);
        check("mid_rst_out", {pool_out1, pool_out2}, 16'h0000);
        check("mid_rst_flags", {14'd0, pool_valid, frame_done}, 16'd0);
        exp_out1 = 8'h00; exp_out2 = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        fill_rand(4);
        run_frame(4, 1000, 2);
        idle_cycle(0);

        for (int f = 0; f < 12; f++) begin
            int s;
            s = int'($urandom_range(0, 12));
            fill_rand(s);
            run_frame(s, 1000, 2);
        end
        idle_cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
